// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the parametrised main-path FIFO (fifo_queue_param).
//   - pause_state_e : back-pressure FSM encoding (RUN=0, PAUSE=1)
//   - ERR_OVF/ERR_UDF : bit positions inside the sticky fifo_error vector
//   - cnt_width()   : occupancy counter width for a given pointer width; one
//                     extra bit so the count can represent a completely full
//                     queue (0..2**ADDR_SIZE)
// -----------------------------------------------------------------------------
package fifo_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } pause_state_e;

  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;
  localparam int ERR_W   = 2;

  function automatic int cnt_width(input int addr_size);
    return addr_size + 1;
  endfunction

endpackage

// File: rtl/fifo_queue_param_if.sv
// -----------------------------------------------------------------------------
// fifo_queue_param_if
// Bus bundle between the upstream packet source / downstream consumer and the
// FIFO. Modport master is the user side, modport slave is the FIFO side.
//
// Handshake: push and pop are requests, not valid/ready pairs. A push is
// accepted when push && (!fifo_full || pop accepted); a pop is accepted when
// pop && !fifo_empty. A request that is not accepted is dropped and latched as
// a sticky error (fifo_error[0] overflow, fifo_error[1] underflow). Upstream
// flow control is fifo_pause (hysteretic) or almost_full/fifo_full.
//
// Signals: push, pop, data_in, afull_th, aempty_th, err_clr (master -> FIFO);
//          data_out, data_valid, data_count, fifo_empty, fifo_full,
//          almost_full, almost_empty, fifo_pause, fifo_error (FIFO -> master)
// -----------------------------------------------------------------------------
interface fifo_queue_param_if #(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 3
);
  import fifo_pkg::*;

  localparam int CNT_SIZE = cnt_width(ADDR_SIZE);

  logic                 push;
  logic                 pop;
  logic [DATA_SIZE-1:0] data_in;
  logic [CNT_SIZE-1:0]  afull_th;
  logic [CNT_SIZE-1:0]  aempty_th;
  logic                 err_clr;

  logic [DATA_SIZE-1:0] data_out;
  logic                 data_valid;
  logic [CNT_SIZE-1:0]  data_count;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 fifo_pause;
  logic [ERR_W-1:0]     fifo_error;

  modport master (
    output push, pop, data_in, afull_th, aempty_th, err_clr,
    input  data_out, data_valid, data_count, fifo_empty, fifo_full,
           almost_full, almost_empty, fifo_pause, fifo_error
  );

  modport slave (
    input  push, pop, data_in, afull_th, aempty_th, err_clr,
    output data_out, data_valid, data_count, fifo_empty, fifo_full,
           almost_full, almost_empty, fifo_pause, fifo_error
  );

endinterface

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// Storage array for fifo_queue_param: 2**ADDR_SIZE words of DATA_SIZE bits.
// Synchronous write, asynchronous read, no reset (contents are don't-care
// after reset; the FIFO pointers define what is valid).
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : combinational read data
// -----------------------------------------------------------------------------
module fifo_ram #(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [DATA_SIZE-1:0] rd_data
);

  logic [DATA_SIZE-1:0] mem [2**ADDR_SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_queue_param.sv
// -----------------------------------------------------------------------------
// fifo_queue_param
// Single-clock main-path FIFO, depth 2**ADDR_SIZE, DATA_SIZE-bit words, with
// programmable almost-full/almost-empty thresholds, hysteretic pause output
// and sticky overflow/underflow reporting.
//
// Ports:
//   clk             : rising-edge clock
//   reset_L         : asynchronous active-low reset, synchronous release
//   bus             : fifo_queue_param_if.slave (requests, thresholds, data,
//                     flags, count, pause, errors)
//   dbg_pause_state : current pause FSM state
//
// Build option:
//   FIFO_FWFT_EN defined   -> first-word fall-through: data_out shows the head
//                             word continuously, data_valid = !fifo_empty.
//   FIFO_FWFT_EN undefined -> data_out registered on an accepted pop, with a
//                             one-cycle data_valid pulse per pop.
// -----------------------------------------------------------------------------
module fifo_queue_param
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 3
) (
  input  logic                    clk,
  input  logic                    reset_L,
  fifo_queue_param_if.slave       bus,
  output pause_state_e            dbg_pause_state
);

  localparam int CNT_SIZE = cnt_width(ADDR_SIZE);
  localparam int DEPTH    = 2**ADDR_SIZE;
  localparam logic [CNT_SIZE-1:0] DEPTH_C = CNT_SIZE'(DEPTH);

  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_SIZE-1:0]  count_q, count_d;
  logic [ERR_W-1:0]     err_q, err_d;
  pause_state_e         pause_state_q;

  logic                 push_acc;
  logic                 pop_acc;
  logic [DATA_SIZE-1:0] rd_data;

  // ---------------------------------------------------------------------------
  // Acceptance, pointer/count next-state and sticky error update
  // ---------------------------------------------------------------------------
  always_comb begin
    // Pop is judged against the registered count only, so an empty FIFO with
    // push+pop rejects the pop: the written word is never bypassed.
    pop_acc  = bus.pop && (count_q != '0);
    // A full FIFO still takes a push when a pop frees a slot this cycle.
    push_acc = bus.push && ((count_q != DEPTH_C) || pop_acc);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + ADDR_SIZE'(1);
    if (pop_acc)  rd_ptr_d = rd_ptr_q + ADDR_SIZE'(1);

    count_d = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CNT_SIZE'(1);
      2'b01:   count_d = count_q - CNT_SIZE'(1);
      default: count_d = count_q;
    endcase

    // Clear first, then OR in this cycle's errors so a new error wins.
    err_d = bus.err_clr ? '0 : err_q;
    if (bus.push && !push_acc) err_d[ERR_OVF] = 1'b1;
    if (bus.pop  && !pop_acc)  err_d[ERR_UDF] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pause FSM. Transitions look at the next count so fifo_pause lines up with
  // data_count in the same cycle. With a collapsed window (afull_th <=
  // aempty_th) there is no hysteresis band and pause follows almost_full.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pause_state_q <= RUN;
    end else if (bus.afull_th <= bus.aempty_th) begin
      pause_state_q <= (count_d >= bus.afull_th) ? PAUSE : RUN;
    end else begin
      case (pause_state_q)
        RUN:   if (count_d >= bus.afull_th)  pause_state_q <= PAUSE;
        PAUSE: if (count_d <= bus.aempty_th) pause_state_q <= RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  fifo_ram #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  // ---------------------------------------------------------------------------
  // Read data path
  // ---------------------------------------------------------------------------
`ifdef FIFO_FWFT_EN
  // Head word is always on data_out; a pop consumes what is being shown.
  assign bus.data_out   = rd_data;
  assign bus.data_valid = (count_q != '0);
`else
  logic [DATA_SIZE-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;

  always_comb begin
    // data_out holds the last popped word until the next accepted pop.
    data_out_d   = pop_acc ? rd_data : data_out_q;
    data_valid_d = pop_acc;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
`endif

  // ---------------------------------------------------------------------------
  // Status outputs: decoded from registered state only, never from push/pop.
  // ---------------------------------------------------------------------------
  assign bus.data_count   = count_q;
  assign bus.fifo_empty   = (count_q == '0);
  assign bus.fifo_full    = (count_q == DEPTH_C);
  assign bus.almost_full  = (count_q >= bus.afull_th);
  assign bus.almost_empty = (count_q <= bus.aempty_th) && (count_q != '0);
  assign bus.fifo_pause   = (pause_state_q == PAUSE);
  assign bus.fifo_error   = err_q;
  assign dbg_pause_state  = pause_state_q;

endmodule

// File: doc/fifo_queue_param.md
# fifo_queue_param

Parametrised second-generation main-path FIFO: a single-clock queue with power-of-two depth and generic data width. It has programmable almost-full/almost-empty thresholds, a hysteretic pause (back-pressure) output, and sticky overflow/underflow error reporting. It sits between the packet source and the VC demux, and replaces fixed-size main buffers wherever a queue with flow control is needed.

## Interface
- DATA_SIZE, 6, data word width in bits
- ADDR_SIZE, 3, pointer width; depth = 2**ADDR_SIZE entries
- CNT_SIZE, ADDR_SIZE+1, occupancy counter width (derived, not overridden)
- clk  in  1  single clock, rising edge
- reset_L  in  1  asynchronous active-low reset
- push  in  1  write request
- pop  in  1  read request
- data_in  in  DATA_SIZE  word to write
- afull_th  in  CNT_SIZE  almost-full threshold
- aempty_th  in  CNT_SIZE  almost-empty threshold
- err_clr  in  1  clears sticky error bits
- data_out  out  DATA_SIZE  read data
- data_valid  out  1  data_out holds a popped or head word
- data_count  out  CNT_SIZE  current occupancy, 0..2**ADDR_SIZE
- fifo_empty  out  1  data_count == 0
- fifo_full  out  1  data_count == 2**ADDR_SIZE
- almost_full  out  1  data_count >= afull_th
- almost_empty  out  1  data_count <= aempty_th and data_count != 0
- fifo_pause  out  1  hysteretic back-pressure to upstream
- fifo_error  out  2  sticky; bit0 overflow, bit1 underflow

## Operation
- Reset (async assert, sync release): pointers, data_count, data_out, data_valid, fifo_pause and fifo_error are all 0. fifo_empty=1, and all other flags are 0.
- Pop is accepted when pop && !fifo_empty.
- Push is accepted when push && (!fifo_full || pop accepted). A push into a full FIFO with a simultaneous accepted pop succeeds.
- Empty with push+pop in the same cycle: push is accepted, pop is rejected and sets underflow. No bypass of the written word.
- An accepted push writes mem[wr_ptr] and increments wr_ptr. An accepted pop increments rd_ptr. Pointers wrap modulo 2**ADDR_SIZE.
- data_count updates by +1 for push only, -1 for pop only, and 0 for both or neither. It never leaves 0..2**ADDR_SIZE.
- A rejected push sets fifo_error[0]. A rejected pop sets fifo_error[1]. Rejected operations do not change pointers, count or memory.
- fifo_error bits stay set until err_clr or reset. If err_clr and a new error occur in the same cycle, the new error wins.
- fifo_pause has two states, RUN and PAUSE:
  - RUN -> PAUSE when the next count >= afull_th.
  - PAUSE -> RUN when the next count <= aempty_th.
  - Otherwise the state holds.
  - If afull_th <= aempty_th, pause simply tracks almost_full.
- Flags are decoded combinationally from the registered count and pointers, so they are glitch-free relative to clk. No flag depends combinationally on push or pop.

## Timing
- Push-to-visibility: a word pushed in cycle N is poppable in cycle N+1. fifo_empty deasserts in N+1.
- Non-FWFT read latency: for a pop accepted in cycle N, data_out holds the word and data_valid=1 in N+1. data_valid is a single-cycle pulse per pop. data_out holds its value until the next accepted pop.
- Flags, data_count and fifo_pause reflect the operations of cycle N in cycle N+1.
- fifo_error is set in the cycle after the offending request.
- Reset asserted mid-operation takes effect immediately on all outputs. Stored memory contents are don't-care.

## Configuration
- FIFO_FWFT_EN defined (first-word fall-through):
  - data_out = mem[rd_ptr] continuously, and data_valid = !fifo_empty.
  - pop acknowledges the word currently shown.
  - Read latency is 0.
- FIFO_FWFT_EN undefined: data_out is registered, with the 1-cycle latency described above.
- Flag, count, pause and error behaviour are identical in both modes.

## Structure
- fifo_pkg holds:
  - the pause state encoding (RUN=1'b0, PAUSE=1'b1);
  - the error bit indices ERR_OVF=0 and ERR_UDF=1;
  - a helper function for the count width (ADDR_SIZE+1).
- Sub-module fifo_ram: 2**ADDR_SIZE x DATA_SIZE, with synchronous write (wr_en, wr_addr, wr_data) and asynchronous read (rd_addr, rd_data). It has no reset. The top level does the registered read when FWFT is off.

## Test plan
DATA_SIZE=6, ADDR_SIZE=3, afull_th=6, aempty_th=2, in both FWFT modes:
- Reset, then push 0x01..0x08 -> fifo_full=1 and data_count=8. Next push of 0x09 sets fifo_error=2'b01 and data_count stays 8.
- From full, pop 8 times -> data_out 0x01..0x08 in order (non-FWFT: one cycle after each pop). fifo_empty=1. An extra pop gives fifo_error[1]=1 with no data_valid pulse.
- Pause hysteresis on fill 0->8 then drain 8->0:
  - fifo_pause rises when count reaches 6;
  - it stays 1 at counts 5..3;
  - it falls when count reaches 2.
- Full with simultaneous push 0x3F and pop -> both accepted, count stays 8, no error. 0x3F emerges after 7 further pops.
- Wrap: 20 push/pop pairs at count 3 -> FIFO order is preserved across pointer wrap and count stays 3.
- Set an error, pulse err_clr -> fifo_error=0. Assert reset_L=0 mid-burst -> all outputs are at reset values in the same cycle.
